// File: rtl/spi_xfer_pkg.sv
// Shared types for the SPI transaction sequencer: FSM/phase encodings, address width
// and the command-byte builder.
package spi_xfer_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_ADDR_WIDTH = (SPI_DATA_WIDTH << 1) - 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD0,
    ST_CMD1,
    ST_DATA,
    ST_DONE
  } xfer_state_e;

  typedef enum logic [1:0] {
    PH_SEND,
    PH_ACK,
    PH_RESP
  } xfer_phase_e;

  // Short form carries addr[5:0]; extended form carries addr[13:8] and sends addr[7:0] next.
  function automatic logic [SPI_DATA_WIDTH-1:0] build_byte0(
    input logic                      write,
    input logic                      ext,
    input logic [SPI_ADDR_WIDTH-1:0] addr
  );
    return {write, ext, (ext ? addr[13:8] : addr[5:0])};
  endfunction

endpackage

// File: rtl/spi_byte_hs.sv
// One-byte SEND/ACK/RESP handshake with spi_master; dv rises the clk after a fire and
// the engine parks in SEND until the owner allows the next byte.
module spi_byte_hs
  import spi_xfer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      byte_ok_i,
  input  logic [SPI_DATA_WIDTH-1:0] byte_i,
  input  logic                      abort_i,
  output logic                      fire_o,
  output logic                      adv_o,
  output logic [SPI_DATA_WIDTH-1:0] m_spi_d_o,
  output logic                      m_spi_dv_o,
  input  logic                      m_spi_dr_i,
  input  logic [SPI_DATA_WIDTH-1:0] s_spi_d_i,
  input  logic                      s_spi_dv_i,
  output logic                      resp_dv_o,
  output logic [SPI_DATA_WIDTH-1:0] resp_d_o
);

  xfer_phase_e               ph_q, ph_d;
  logic                      dv_q;
  logic [SPI_DATA_WIDTH-1:0] d_q;
  logic                      fire;

  assign fire = (ph_q == PH_SEND) && start_i && byte_ok_i && m_spi_dr_i && !abort_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= PH_SEND;
      dv_q <= 1'b0;
      d_q  <= '0;
    end else begin
      ph_q <= ph_d;
      dv_q <= (ph_d == PH_ACK);
      if (fire) d_q <= byte_i;
    end
  end

  always_comb begin
    ph_d = ph_q;
    case (ph_q)
      PH_SEND: if (fire) ph_d = PH_ACK;
      PH_ACK:  if (!m_spi_dr_i) ph_d = PH_RESP;
      PH_RESP: if (s_spi_dv_i) ph_d = PH_SEND;
      default: ph_d = PH_SEND;
    endcase
    if (abort_i) ph_d = PH_SEND;
  end

  always_comb begin
    fire_o     = fire;
    adv_o      = (ph_d != ph_q);
    m_spi_d_o  = d_q;
    m_spi_dv_o = dv_q;
    resp_dv_o  = (ph_q == PH_RESP) && s_spi_dv_i && !abort_i;
    resp_d_o   = s_spi_d_i;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Register-access sequencer feeding spi_master one byte at a time; write stalls hold in SEND.
// Optional watchdog via SPI_XFER_TIMEOUT_EN aborts a stuck byte, sets err and ends the transfer.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_ext,
  input  logic [SPI_ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]      req_len,
  input  logic [SPI_DATA_WIDTH-1:0] wr_d,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [SPI_DATA_WIDTH-1:0] m_spi_d,
  output logic                      m_spi_dv,
  input  logic                      m_spi_dr,
  input  logic [SPI_DATA_WIDTH-1:0] s_spi_d,
  input  logic                      s_spi_dv,
  output logic [SPI_DATA_WIDTH-1:0] status_d,
  output logic                      status_dv,
  output logic [SPI_DATA_WIDTH-1:0] rd_d,
  output logic                      rd_dv,
  output logic                      done,
  output logic                      err
);

  xfer_state_e               st_q, st_d;
  logic                      wr_q, ext_q, wr_ready_q;
  logic [SPI_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [SPI_DATA_WIDTH-1:0] status_q, tx_byte, resp_d;
  logic                      accept, active, byte_ok, hs_fire, hs_adv, resp_dv, tmo;

  assign accept  = (st_q == ST_IDLE) && req_valid;
  assign active  = (st_q == ST_CMD0) || (st_q == ST_CMD1) || (st_q == ST_DATA);
  assign byte_ok = !((st_q == ST_DATA) && wr_q) || wr_valid;

  always_comb begin
    tx_byte = '0;
    case (st_q)
      ST_CMD0: tx_byte = build_byte0(wr_q, ext_q, addr_q);
      ST_CMD1: tx_byte = addr_q[7:0];
      ST_DATA: tx_byte = wr_q ? wr_d : '0;
      default: tx_byte = '0;
    endcase
  end

  spi_byte_hs u_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (active),
    .byte_ok_i  (byte_ok),
    .byte_i     (tx_byte),
    .abort_i    (tmo),
    .fire_o     (hs_fire),
    .adv_o      (hs_adv),
    .m_spi_d_o  (m_spi_d),
    .m_spi_dv_o (m_spi_dv),
    .m_spi_dr_i (m_spi_dr),
    .s_spi_d_i  (s_spi_d),
    .s_spi_dv_i (s_spi_dv),
    .resp_dv_o  (resp_dv),
    .resp_d_o   (resp_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      wr_q       <= 1'b0;
      ext_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      status_q   <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      wr_ready_q <= hs_fire && (st_q == ST_DATA) && wr_q;
      if (accept) begin
        wr_q   <= req_write;
        ext_q  <= req_ext;
        addr_q <= req_addr;
      end
      if (resp_dv && (st_q == ST_CMD0)) status_q <= resp_d;
    end
  end

  // Data count is loaded once and only decremented on a data response, so it never wraps.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_IDLE: if (accept) begin
        st_d  = ST_CMD0;
        cnt_d = req_len;
      end
      ST_CMD0: if (resp_dv) begin
        if (ext_q)             st_d = ST_CMD1;
        else if (cnt_q == '0)  st_d = ST_DONE;
        else                   st_d = ST_DATA;
      end
      ST_CMD1: if (resp_dv) st_d = (cnt_q == '0) ? ST_DONE : ST_DATA;
      ST_DATA: if (resp_dv) begin
        cnt_d = cnt_q - LEN_WIDTH'(1);
        if (cnt_q == LEN_WIDTH'(1)) st_d = ST_DONE;
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (tmo) st_d = ST_DONE;
  end

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             err_q;

  assign tmo = active && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Timer restarts whenever the byte phase or the transaction state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= (!active || hs_adv || (st_d != st_q)) ? '0 : tmr_q + TMR_W'(1);
      if (accept)   err_q <= 1'b0;
      else if (tmo) err_q <= 1'b1;
    end
  end
`else
  logic err_q;
  logic unused_tmo_cfg;

  assign tmo            = 1'b0;
  assign err_q          = 1'b0;
  assign unused_tmo_cfg = hs_adv ^ (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    req_ready = (st_q == ST_IDLE);
    done      = (st_q == ST_DONE);
    wr_ready  = wr_ready_q;
    status_dv = resp_dv && (st_q == ST_CMD0);
    status_d  = status_dv ? resp_d : status_q;
    rd_dv     = resp_dv && (st_q == ST_DATA) && !wr_q;
    rd_d      = rd_dv ? resp_d : '0;
    err       = err_q;
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: emulated spi_master/slave register file with random handshake
// delays, directed vector table, random transactions and reset/stall/timeout sequences.
module tb_spi_xfer_ctrl;

  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_write, req_ext;
  logic [13:0] req_addr;
  logic [7:0]  req_len;
  logic [7:0]  wr_d, m_spi_d, s_spi_d, status_d, rd_d;
  logic        wr_valid, wr_ready, m_spi_dv, m_spi_dr, s_spi_dv;
  logic        status_dv, rd_dv, done, err;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.LEN_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_ext(req_ext),
    .req_addr(req_addr), .req_len(req_len),
    .wr_d(wr_d), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .m_spi_d(m_spi_d), .m_spi_dv(m_spi_dv), .m_spi_dr(m_spi_dr),
    .s_spi_d(s_spi_d), .s_spi_dv(s_spi_dv),
    .status_d(status_d), .status_dv(status_dv), .rd_d(rd_d), .rd_dv(rd_dv),
    .done(done), .err(err)
  );

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mem_init(input int a);
    return a[7:0] ^ 8'h1A;
  endfunction

  // Slave side: spi_master + register file behind it
  logic [7:0] smem [0:16383];
  logic [7:0] slv_status = 8'h00;
  bit         force_dr = 1'b0;
  logic [7:0] sent_q[$];

  initial begin : slave
    int st, cnt, idx, dcnt;
    logic sw, se;
    logic [13:0] sa;
    logic [7:0] b, resp;
    for (int i = 0; i < 16384; i++) smem[i] = mem_init(i);
    m_spi_dr = 1'b1; s_spi_dv = 1'b0; s_spi_d = 8'h00;
    st = 0; cnt = 0; idx = 0; dcnt = 0; sw = 0; se = 0; sa = '0; resp = '0; b = '0;
    forever begin
      tick();
      s_spi_dv = 1'b0;
      if (!rst_n) begin
        st = 0; idx = 0; m_spi_dr = 1'b1;
      end else begin
        if (done) idx = 0;
        case (st)
          0: begin
            m_spi_dr = !force_dr;
            if (m_spi_dv) begin
              b = m_spi_d;
              sent_q.push_back(b);
              if (idx == 0) begin
                sw = b[7]; se = b[6]; sa = {8'h00, b[5:0]}; dcnt = 0; resp = slv_status;
              end else if (idx == 1 && se) begin
                sa = {sa[5:0], b}; resp = 8'h5A;
              end else begin
                if (sw) begin
                  smem[(int'(sa) + dcnt) % 16384] = b; resp = 8'h3C;
                end else resp = smem[(int'(sa) + dcnt) % 16384];
                dcnt++;
              end
              idx++; st = 1; cnt = $urandom_range(0, 2);
            end
          end
          1: if (cnt == 0) begin m_spi_dr = 1'b0; st = 2; cnt = $urandom_range(1, 3); end
             else cnt--;
          default: if (cnt == 0) begin
              s_spi_dv = 1'b1; s_spi_d = resp; m_spi_dr = !force_dr; st = 0;
            end else cnt--;
        endcase
      end
    end
  end

  // Host-side observation of DUT outputs
  logic [7:0] stat_q[$];
  logic [7:0] rd_q[$];
  int wr_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (status_dv) stat_q.push_back(status_d);
      if (rd_dv)     rd_q.push_back(rd_d);
      if (wr_ready)  wr_cnt++;
      if (done)      done_cnt++;
    end
  end

  logic [7:0] ref_mem [0:16383];

  task automatic req_go(input bit w, input bit e, input logic [13:0] addr, input int len);
    int n;
    req_write = w; req_ext = e; req_addr = addr; req_len = 8'(len);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic xfer(input bit w, input bit e, input logic [13:0] addr, input int len,
                      input logic [7:0] st, input logic [7:0] wd0, input int stall_idx,
                      input string tag, output logic [7:0] b0, output logic [7:0] r0);
    logic [7:0] exp_b[$];
    logic [7:0] wdat[$];
    logic [7:0] exp_rd[$];
    int s_sent, s_stat, s_rd, s_wr, s_done, k, n, ea, rises;
    logic pdv;
    ea = e ? int'(addr) : int'(addr) % 64;
    for (int i = 0; i < len; i++) wdat.push_back(wd0 + 8'(i * 29));
    exp_b.push_back(8'(int'(w) * 128 + int'(e) * 64 + (e ? int'(addr) / 256 : int'(addr) % 64)));
    if (e) exp_b.push_back(8'(int'(addr) % 256));
    for (int i = 0; i < len; i++) begin
      if (w) begin
        exp_b.push_back(wdat[i]);
        ref_mem[(ea + i) % 16384] = wdat[i];
      end else begin
        exp_b.push_back(8'h00);
        exp_rd.push_back(ref_mem[(ea + i) % 16384]);
      end
    end
    s_sent = sent_q.size(); s_stat = stat_q.size(); s_rd = rd_q.size();
    s_wr = wr_cnt; s_done = done_cnt;
    slv_status = st;
    wr_valid = w && (len > 0);
    wr_d = (w && len > 0) ? wdat[0] : 8'h00;
    req_go(w, e, addr, len);
    chk({tag, " ready low while busy"}, req_ready, 0);
    k = 0; n = 0; rises = 0;
    while (done_cnt == s_done && n < 3000) begin
      tick(); n++;
      if (w && wr_ready) begin
        k++;
        if (k == stall_idx) begin
          wr_valid = 1'b0;
          pdv = m_spi_dv;
          repeat (50) begin
            tick(); n++;
            if (m_spi_dv && !pdv) rises++;
            pdv = m_spi_dv;
          end
        end
        wr_valid = (k < len);
        if (k < len) wr_d = wdat[k];
      end
    end
    wr_valid = 1'b0;
    tick(); tick();
    chk({tag, " done pulses"}, done_cnt - s_done, 1);
    chk({tag, " ready after done"}, req_ready, 1);
    chk({tag, " err"}, err, 0);
    chk({tag, " byte count"}, sent_q.size() - s_sent, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (s_sent + i < sent_q.size()) chk({tag, " byte"}, sent_q[s_sent + i], exp_b[i]);
    chk({tag, " status pulses"}, stat_q.size() - s_stat, 1);
    if (stat_q.size() > s_stat) chk({tag, " status value"}, stat_q[s_stat], st);
    chk({tag, " rd pulses"}, rd_q.size() - s_rd, exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      if (s_rd + i < rd_q.size()) chk({tag, " rd data"}, rd_q[s_rd + i], exp_rd[i]);
    chk({tag, " wr_ready pulses"}, wr_cnt - s_wr, w ? len : 0);
    if (stall_idx >= 0) chk({tag, " dv rise during stall"}, rises, 0);
    b0 = (sent_q.size() > s_sent) ? sent_q[s_sent] : 8'hxx;
    r0 = (rd_q.size() > s_rd) ? rd_q[s_rd] : 8'hxx;
  endtask

  typedef struct {
    bit          w;
    bit          e;
    logic [13:0] addr;
    int          len;
    logic [7:0]  st;
    logic [7:0]  wd0;
    logic [7:0]  exp_b0;
    int          exp_rd0;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] b0, r0;
    int n, s_done;
    tbl[0] = '{1'b0, 1'b1, 14'h0983, 1, 8'hA5, 8'h00, 8'h49, 32'h99};
    tbl[1] = '{1'b1, 1'b1, 14'h0003, 1, 8'h12, 8'hE7, 8'hC0, -1};
    tbl[2] = '{1'b0, 1'b1, 14'h0003, 1, 8'h34, 8'h00, 8'h40, 32'hE7};
    tbl[3] = '{1'b0, 1'b0, 14'h0011, 0, 8'h56, 8'h00, 8'h11, -1};
    tbl[4] = '{1'b1, 1'b0, 14'h3FC5, 2, 8'h78, 8'h5B, 8'h85, -1};
    tbl[5] = '{1'b0, 1'b0, 14'h0005, 2, 8'h9A, 8'h00, 8'h05, 32'h5B};

    for (int i = 0; i < 16384; i++) ref_mem[i] = mem_init(i);
    req_valid = 0; req_write = 0; req_ext = 0; req_addr = '0; req_len = '0;
    wr_d = '0; wr_valid = 0;

    repeat (3) tick();
    chk("reset req_ready", req_ready, 1);
    chk("reset m_spi_dv", m_spi_dv, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset status/rd/wr", {status_dv, rd_dv, wr_ready}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      xfer(tbl[i].w, tbl[i].e, tbl[i].addr, tbl[i].len, tbl[i].st, tbl[i].wd0, -1, "tbl", b0, r0);
      chk("tbl byte0", b0, tbl[i].exp_b0);
      if (tbl[i].exp_rd0 >= 0) chk("tbl rd0", r0, tbl[i].exp_rd0);
    end

    xfer(1'b1, 1'b1, 14'h0200, 3, 8'h61, 8'h10, 2, "stall", b0, r0);
    xfer(1'b0, 1'b1, 14'h0200, 3, 8'h62, 8'h00, -1, "stall rb", b0, r0);

    for (int i = 0; i < 25; i++)
      xfer(1'($urandom % 2), 1'($urandom % 2), 14'($urandom_range(0, 16383)),
           $urandom_range(0, 4), 8'($urandom), 8'($urandom), -1, "rand", b0, r0);

    // Reset while a byte sits in ACK
    slv_status = 8'h77;
    req_go(1'b0, 1'b1, 14'h0100, 2);
    n = 0;
    while (!m_spi_dv && n < 100) begin tick(); n++; end
    chk("rst dv seen before reset", m_spi_dv, 1);
    s_done = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst m_spi_dv drop", m_spi_dv, 0);
    chk("rst req_ready", req_ready, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rst no done", done_cnt - s_done, 0);
    xfer(1'b0, 1'b1, 14'h0100, 2, 8'h78, 8'h00, -1, "post rst", b0, r0);

`ifdef SPI_XFER_TIMEOUT_EN
    force_dr = 1'b1;
    tick(); tick();
    s_done = done_cnt;
    req_go(1'b0, 1'b0, 14'h0001, 0);
    n = 0;
    while (done_cnt == s_done && n < TMO + 200) begin tick(); n++; end
    tick();
    chk("tmo done pulse", done_cnt - s_done, 1);
    chk("tmo err set", err, 1);
    chk("tmo not early", (n >= TMO - 4), 1);
    chk("tmo dv low", m_spi_dv, 0);
    force_dr = 1'b0;
    tick(); tick();
    chk("tmo err sticky", err, 1);
    xfer(1'b0, 1'b0, 14'h0001, 1, 8'h5E, 8'h00, -1, "after tmo", b0, r0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
